// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a fixed number of multiplier products, holds the result
//               until acknowledged, and tracks carry-out with a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int p_width     = 6,
    parameter int p_acc_width = 16,
    parameter int p_count     = 8
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_reset,
    input  logic                   i_w_valid,
    input  logic [2*p_width-1:0]   i_w_p,
    output logic                   o_w_ready,
    input  logic                   i_w_clear,
    output logic [p_acc_width-1:0] o_w_acc,
    output logic [7:0]             o_w_count,
    output logic                   o_w_done,
    output logic                   o_w_overflow,
    input  logic                   i_w_ack
);

    localparam logic [7:0] c_count_last = 8'(p_count);
    localparam int         c_pad        = p_acc_width - 2*p_width + 1;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [p_acc_width-1:0] r_acc;
    logic [7:0]             r_count;
    logic                   r_overflow;

    logic                   w_transfer;
    logic                   w_flush;
    logic [p_acc_width:0]   w_sum;
    logic [7:0]             w_count_inc;

    // Clear wins over a simultaneous product, so it is folded into the transfer term.
    assign w_transfer  = (r_state == ST_ACC) && i_w_valid && !i_w_clear;
    assign w_flush     = i_w_clear || ((r_state == ST_HOLD) && i_w_ack);
    assign w_sum       = {1'b0, r_acc} + {{c_pad{1'b0}}, i_w_p};
    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = ST_ACC;
        end else if (w_transfer && (w_count_inc == c_count_last)) begin
            w_state_next = ST_HOLD;
        end
    end

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_transfer) begin
            r_acc      <= w_sum[p_acc_width-1:0];
            r_count    <= w_count_inc;
            r_overflow <= r_overflow | w_sum[p_acc_width];
        end
    end

    assign o_w_ready    = (r_state == ST_ACC);
    assign o_w_done     = (r_state == ST_HOLD);
    assign o_w_acc      = r_acc;
    assign o_w_count    = r_count;
    assign o_w_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Self-checking bench: directed scenarios plus randomized traffic
//               compared against a plain-arithmetic model of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_valid, a_clear, a_ack, a_ready, a_done, a_ovf;
    logic [11:0] a_p;
    logic [15:0] a_acc;
    logic [7:0]  a_count;

    logic        b_valid, b_clear, b_ack, b_ready, b_done, b_ovf;
    logic [11:0] b_p;
    logic [11:0] b_acc;
    logic [7:0]  b_count;

    int total = 0;
    int bad   = 0;

    product_accumulator #(.p_width(6), .p_acc_width(16), .p_count(4)) dut_a (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_valid(a_valid), .i_w_p(a_p),
        .o_w_ready(a_ready), .i_w_clear(a_clear), .o_w_acc(a_acc),
        .o_w_count(a_count), .o_w_done(a_done), .o_w_overflow(a_ovf),
        .i_w_ack(a_ack)
    );

    product_accumulator #(.p_width(6), .p_acc_width(12), .p_count(8)) dut_b (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_valid(b_valid), .i_w_p(b_p),
        .o_w_ready(b_ready), .i_w_clear(b_clear), .o_w_acc(b_acc),
        .o_w_count(b_count), .o_w_done(b_done), .o_w_overflow(b_ovf),
        .i_w_ack(b_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int acc, input int cnt, input int done, input int ovf);
        chk({tag, ".acc"},   a_acc,   64'(acc));
        chk({tag, ".count"}, a_count, 64'(cnt));
        chk({tag, ".done"},  a_done,  64'(done));
        chk({tag, ".ready"}, a_ready, 64'(done == 0));
        chk({tag, ".ovf"},   a_ovf,   64'(ovf));
    endtask

    task automatic chk_b(input string tag, input int acc, input int cnt, input int done, input int ovf);
        chk({tag, ".acc"},   b_acc,   64'(acc));
        chk({tag, ".count"}, b_count, 64'(cnt));
        chk({tag, ".done"},  b_done,  64'(done));
        chk({tag, ".ready"}, b_ready, 64'(done == 0));
        chk({tag, ".ovf"},   b_ovf,   64'(ovf));
    endtask

    int     ref_sum [32];
    longint m_sum;
    int     m_n;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_clear = 1'b0; a_ack = 1'b0; a_p = 12'd50;
        b_valid = 1'b1; b_clear = 1'b0; b_ack = 1'b0; b_p = 12'd50;
        repeat (3) tick();
        chk_a("reset_a", 0, 0, 0, 0);
        chk_b("reset_b", 0, 0, 0, 0);

        // Four 225s into the p_count=4 instance; first edge after reset must accept.
        rst = 1'b0; b_valid = 1'b0; a_p = 12'd225;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("fill.count", a_count, 64'(i));
            chk("fill.acc",   a_acc,   64'(225 * i));
        end
        chk_a("hold900", 900, 4, 1, 0);

        a_p = 12'd7;
        repeat (5) begin
            tick();
            chk_a("hold_valid", 900, 4, 1, 0);
        end
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk_a("ack_clear", 0, 0, 0, 0);
        tick();
        chk_a("accept7", 7, 1, 0, 0);
        a_valid = 1'b0;

        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk_a("ack_in_acc", 7, 1, 0, 0);

        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk_a("clear1", 0, 0, 0, 0);
        a_valid = 1'b1; a_p = 12'd10;
        repeat (3) tick();
        chk_a("three10", 30, 3, 0, 0);
        a_clear = 1'b1; a_p = 12'd5;
        tick();
        a_clear = 1'b0; a_valid = 1'b0;
        chk_a("clear_drop", 0, 0, 0, 0);
        tick();
        chk_a("clear_after", 0, 0, 0, 0);

        a_valid = 1'b1; a_p = 12'd1;
        repeat (4) tick();
        chk_a("hold4", 4, 4, 1, 0);
        a_clear = 1'b1; a_valid = 1'b0;
        tick();
        a_clear = 1'b0;
        chk_a("clear_hold", 0, 0, 0, 0);

        // Asynchronous reset between edges with a partial sum of two.
        a_valid = 1'b1; a_p = 12'd3;
        repeat (2) tick();
        chk_a("pre_rst", 6, 2, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        repeat (2) tick();
        chk_a("rst_valid", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_a("post_rst", 3, 1, 0, 0);
        a_p = 12'd2;
        repeat (3) tick();
        chk_a("hold9", 9, 4, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk_a("rst_hold", 0, 0, 0, 0);
        tick();
        rst = 1'b0; a_valid = 1'b0;

        // 12-bit accumulator: wrap and sticky overflow.
        b_valid = 1'b1; b_p = 12'd3969;
        repeat (2) tick();
        chk_b("wrap", 3842, 2, 0, 1);
        b_p = 12'd0;
        repeat (6) tick();
        chk_b("wrap_hold", 3842, 8, 1, 1);
        b_valid = 1'b0;
        tick();
        chk_b("wrap_hold2", 3842, 8, 1, 1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk_b("wrap_ack", 0, 0, 0, 0);

        b_valid = 1'b1; b_p = 12'd3969;
        tick();
        b_p = 12'd127;
        tick();
        b_valid = 1'b0;
        chk_b("exact_pow2", 0, 2, 0, 1);
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        chk_b("exact_clear", 0, 0, 0, 0);

        // All 16x16 products in groups of 8 with random ack latency.
        for (int g = 0; g < 32; g++) ref_sum[g] = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                ref_sum[(a * 16 + b) / 8] += a * b;

        fork
            begin : prod
                int  n;
                logic rdy;
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        b_p = 12'(a * b);
                        b_valid = 1'b1;
                        n = 0;
                        do begin
                            rdy = b_ready;
                            tick();
                            n++;
                        end while (!rdy && n < 200);
                        if (!rdy) chk("prod_timeout", 64'(0), 64'(1));
                        b_valid = 1'b0;
                        if ($urandom_range(0, 3) == 0) tick();
                    end
                end
            end
            begin : cons
                int n;
                int d;
                for (int g = 0; g < 32; g++) begin
                    n = 0;
                    while (!b_done && n < 200) begin
                        tick();
                        n++;
                    end
                    if (!b_done) begin
                        chk("cons_timeout", 64'(0), 64'(1));
                        break;
                    end
                    chk_b($sformatf("group%0d", g), ref_sum[g], 8, 1, 0);
                    d = $urandom_range(0, 3);
                    repeat (d) begin
                        tick();
                        chk("group_stable", b_acc, 64'(ref_sum[g]));
                    end
                    b_ack = 1'b1;
                    tick();
                    b_ack = 1'b0;
                end
            end
        join
        chk_b("groups_end", 0, 0, 0, 0);

        // Random traffic against a true-sum model.
        m_sum = 0;
        m_n   = 0;
        for (int i = 0; i < 300; i++) begin
            b_valid = 1'($urandom_range(0, 1));
            b_p     = 12'($urandom);
            b_clear = ($urandom_range(0, 15) == 0);
            b_ack   = ($urandom_range(0, 2) == 0);
            if (b_clear || (m_n == 8 && b_ack)) begin
                m_sum = 0;
                m_n   = 0;
            end else if (m_n < 8 && b_valid) begin
                m_sum += longint'(b_p);
                m_n++;
            end
            tick();
            chk_b("rand", int'(m_sum % 4096), m_n, int'(m_n == 8), int'(m_sum >= 4096));
        end
        b_valid = 1'b0; b_clear = 1'b0; b_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The module SHALL have parameter p_width, default 6, giving the operand width of the upstream multiplier; products are 2*p_width bits.
REQ-002 The module SHALL have parameter p_acc_width, default 16, giving the accumulator width; legal only when p_acc_width >= 2*p_width.
REQ-003 The module SHALL have parameter p_count, default 8, giving the number of products summed per result; legal range 2..255.
REQ-004 The module SHALL have port i_w_clk, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port i_w_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port i_w_valid, input, 1 bit: i_w_p carries a valid product.
REQ-007 The module SHALL have port i_w_p, input, 2*p_width bits: unsigned product from the multiplier.
REQ-008 The module SHALL have port o_w_ready, output, 1 bit: the block can accept a product this cycle.
REQ-009 The module SHALL have port i_w_clear, input, 1 bit: synchronous abort of the current sum.
REQ-010 The module SHALL have port o_w_acc, output, p_acc_width bits: the running or final sum.
REQ-011 The module SHALL have port o_w_count, output, 8 bits: number of products accepted in the current sum.
REQ-012 The module SHALL have port o_w_done, output, 1 bit: o_w_acc holds a completed result.
REQ-013 The module SHALL have port o_w_overflow, output, 1 bit: sticky carry-out flag for the current sum.
REQ-014 The module SHALL have port i_w_ack, input, 1 bit: the consumer takes the completed result.

Function
REQ-015 The block SHALL implement two states: ACC (o_w_ready=1, o_w_done=0) and HOLD (o_w_ready=0, o_w_done=1); o_w_ready and o_w_done are decoded from the state only.
REQ-016 A transfer SHALL occur on a rising edge with state ACC, i_w_valid=1 and i_w_clear=0.
REQ-017 On a transfer, o_w_acc SHALL become (o_w_acc + zero-extended i_w_p) mod 2^p_acc_width, and o_w_count SHALL increment, both visible one cycle later.
REQ-018 o_w_overflow SHALL be set on any transfer whose addition carries out of bit p_acc_width-1, and SHALL remain set until the sum is cleared.
REQ-019 A transfer that makes o_w_count equal p_count SHALL move the state to HOLD on the same edge, giving 1-cycle latency from the last product to o_w_done=1.
REQ-020 In HOLD, o_w_acc, o_w_count and o_w_overflow SHALL stay stable, and i_w_valid SHALL be ignored.
REQ-021 In HOLD with i_w_ack=1, the next edge SHALL set o_w_acc=0, o_w_count=0, o_w_overflow=0 and the state to ACC.
REQ-022 i_w_ack SHALL be ignored in ACC.
REQ-023 i_w_clear=1 in any state SHALL cause the same clearing as REQ-021 on the next edge; it SHALL take priority over a simultaneous valid or ack, and that product SHALL be dropped.
REQ-024 i_w_valid held high while o_w_ready=0 SHALL NOT be lost by the block; it SHALL be accepted when ACC is re-entered if still asserted (the producer holds data until accepted).
REQ-025 A combination of products whose true sum equals exactly 2^p_acc_width SHALL yield o_w_acc=0 with o_w_overflow=1.

Reset
REQ-026 Asserting i_w_reset SHALL immediately, without waiting for a clock edge, force the state to ACC, o_w_acc=0, o_w_count=0, o_w_overflow=0, o_w_done=0 and o_w_ready=1.
REQ-027 No transfer SHALL occur on any edge while i_w_reset=1, even with i_w_valid=1.
REQ-028 Reset asserted mid-sum or in HOLD SHALL discard the partial or completed result.
REQ-029 The first transfer SHALL be possible on the first rising edge after i_w_reset deasserts.

Verification
REQ-030 With p_count=4, present four products of 225 (15*15) back-to-back -> o_w_acc=900, o_w_count=4, o_w_done=1 one cycle after the 4th transfer, and o_w_ready=0.
REQ-031 In HOLD, hold i_w_valid=1 with i_w_p=7 for 5 cycles, then pulse i_w_ack -> o_w_acc stays 900 throughout, then becomes 0; the next edge accepts 7, giving o_w_acc=7.
REQ-032 With p_acc_width=12 and p_width=6, present 3969 then 3969 -> o_w_acc=3842 and o_w_overflow=1; the flag stays 1 through HOLD and clears on i_w_ack.
REQ-033 After 3 transfers of 10, assert i_w_clear together with i_w_valid=1 (i_w_p=5) -> o_w_acc=0, o_w_count=0, and the 5 is not summed.
REQ-034 Assert i_w_reset asynchronously between edges with o_w_count=2 -> all outputs reach their reset values before the next edge; with i_w_valid held high during reset, o_w_count stays 0.
REQ-035 Drive all 256 products a*b for a,b in 0..15 in nested-loop order with p_count=8 and random ack delays of 0-3 cycles -> the 32 results match the reference sums of consecutive groups of 8 products, with no product dropped or duplicated.
